// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words ahead of the IF stage and flushes on redirect.
// Optional same-cycle ack-to-head bypass when PREFETCH_BYPASS_EN is defined.
module instr_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         redirect_i,
    input  logic [31:0]                  redirect_pc_i,
    output logic                         mem_req_o,
    output logic [31:0]                  mem_addr_o,
    input  logic                         mem_ack_i,
    input  logic [31:0]                  mem_data_i,
    input  logic                         deq_i,
    output logic                         valid_o,
    output logic [31:0]                  instr_o,
    output logic [31:0]                  pc_o,
    output logic [31:0]                  pc_plus4_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      instr_mem_q [DEPTH];
    logic [31:0]      instr_mem_d [DEPTH];
    logic [31:0]      pc_mem_q    [DEPTH];
    logic [31:0]      pc_mem_d    [DEPTH];

    logic ack_accept;
    logic head_valid;
    logic bypass_hit;
    logic push;
    logic pop;

    // Accepted ack: a live request completing without a flush in the same cycle.
    always_comb begin
        ack_accept = mem_ack_i && (state_q == ST_REQ) && !redirect_i;
        head_valid = (count_q != '0);
`ifdef PREFETCH_BYPASS_EN
        bypass_hit = ack_accept && !head_valid;
`else
        bypass_hit = 1'b0;
`endif
        pop  = deq_i && head_valid && !redirect_i;
        push = ack_accept && !(bypass_hit && deq_i);
    end

    // Queue pointers, occupancy and storage.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        if (redirect_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                instr_mem_d[wr_ptr_q] = mem_data_i;
                pc_mem_d[wr_ptr_q]    = fetch_pc_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Fetch PC and the address held on the memory port while a request is open.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
        end else if (ack_accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        req_addr_d = fetch_pc_d;
        if ((state_q != ST_IDLE) && !mem_ack_i) begin
            req_addr_d = req_addr_q;
        end
    end

    // FSM next state; issue only while a slot remains for the outstanding word.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (redirect_i || (count_q < DEPTH_CNT)) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack_i) begin
                    state_d = (count_d < DEPTH_CNT) ? ST_REQ : ST_IDLE;
                end else if (redirect_i) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (mem_ack_i) begin
                    state_d = (count_d < DEPTH_CNT) ? ST_REQ : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            req_addr_q  <= req_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
        end
    end

    // FSM outputs.
    always_comb begin
        mem_req_o  = 1'b0;
        mem_addr_o = req_addr_q;
        if (state_q != ST_IDLE) begin
            mem_req_o = 1'b1;
        end
    end

    // Head-of-queue outputs; the bypass path presents the returning word directly.
    always_comb begin
        valid_o = head_valid;
        instr_o = instr_mem_q[rd_ptr_q];
        pc_o    = pc_mem_q[rd_ptr_q];
        count_o = count_q;
        if (bypass_hit) begin
            valid_o = 1'b1;
            instr_o = mem_data_i;
            pc_o    = fetch_pc_q;
        end
        pc_plus4_o = pc_o + 32'd4;
    end

    // The issue check reserves a slot for the in-flight word, so this can never fire.
    push_not_full_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && (count_q == DEPTH_CNT)));

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed self-checking bench for instr_prefetch_queue (DEPTH=4, RESET_PC=0).
module tb_instr_prefetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             redirect_i;
    logic [31:0]      redirect_pc_i;
    logic             mem_req_o;
    logic [31:0]      mem_addr_o;
    logic             mem_ack_i;
    logic [31:0]      mem_data_i;
    logic             deq_i;
    logic             valid_o;
    logic [31:0]      instr_o;
    logic [31:0]      pc_o;
    logic [31:0]      pc_plus4_o;
    logic [CNT_W-1:0] count_o;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          auto_mem;
    int          ack_lat;
    int          wait_cnt;
    int          n_acks;
    logic [31:0] ack_addr [16];

    instr_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_data_i    (mem_data_i),
        .deq_i         (deq_i),
        .valid_o       (valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .count_o       (count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock; the memory model (when enabled) answers after ack_lat wait cycles.
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (auto_mem) begin
            if (mem_req_o && !rst_i) begin
                if (wait_cnt >= ack_lat) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = mem_word(mem_addr_o);
                    if (n_acks < 16) ack_addr[n_acks] = mem_addr_o;
                    n_acks++;
                    wait_cnt = 0;
                end else begin
                    mem_ack_i = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_ack_i = 1'b0;
                wait_cnt  = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        mem_ack_i     = 1'b0;
        mem_data_i    = '0;
        deq_i         = 1'b0;
        auto_mem      = 1'b0;
        ack_lat       = 1;
        wait_cnt      = 0;
        n_acks        = 0;
        tick();
        tick();
        check({tag, "_rst_count"}, 32'(count_o), 32'd0);
        check({tag, "_rst_valid"}, 32'(valid_o), 32'd0);
        check({tag, "_rst_instr"}, instr_o, 32'd0);
        check({tag, "_rst_pc"}, pc_o, 32'd0);
        check({tag, "_rst_pc4"}, pc_plus4_o, 32'd4);
        check({tag, "_rst_req"}, 32'(mem_req_o), 32'd0);
        rst_i = 1'b0;
    endtask

    initial begin
        bit          ok;
        bit          prev_valid;
        int          pops;
        logic [31:0] exp_pc;

        // Fill from reset with one-cycle memory.
        do_reset("s1");
        auto_mem = 1'b1;
        ack_lat  = 1;
        for (int i = 0; i < 12; i++) tick();
        check("s1_n_acks", 32'(n_acks), 32'd4);
        check("s1_addr0", ack_addr[0], 32'h0);
        check("s1_addr1", ack_addr[1], 32'h4);
        check("s1_addr2", ack_addr[2], 32'h8);
        check("s1_addr3", ack_addr[3], 32'hC);
        check("s1_count", 32'(count_o), 32'd4);
        check("s1_req_idle", 32'(mem_req_o), 32'd0);
        check("s1_pc", pc_o, 32'h0);
        check("s1_pc4", pc_plus4_o, 32'h4);
        check("s1_instr", instr_o, mem_word(32'h0));

        // Single pop from full reopens fetch at 0x10.
        deq_i = 1'b1;
        tick();
        deq_i = 1'b0;
        check("s2_count", 32'(count_o), 32'd3);
        check("s2_pc", pc_o, 32'h4);
        check("s2_instr", instr_o, mem_word(32'h4));
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (mem_req_o) ok = 1'b1;
        end
        check("s2_req_seen", 32'(ok), 32'd1);
        check("s2_addr", mem_addr_o, 32'h10);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (count_o == CNT_W'(4)) ok = 1'b1;
        end
        check("s2_refill", 32'(ok), 32'd1);
        check("s2_ack_addr", ack_addr[4], 32'h10);

        // Redirect while 0x8 is pending; the late word must be dropped.
        do_reset("s3");
        auto_mem = 1'b1;
        ack_lat  = 1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (mem_req_o && (mem_addr_o == 32'h8) && !mem_ack_i) ok = 1'b1;
        end
        check("s3_pending8", 32'(ok), 32'd1);
        auto_mem      = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        tick();
        redirect_i = 1'b0;
        check("s3_drop_req", 32'(mem_req_o), 32'd1);
        check("s3_drop_addr", mem_addr_o, 32'h8);
        check("s3_flush_count", 32'(count_o), 32'd0);
        check("s3_flush_valid", 32'(valid_o), 32'd0);
        tick();
        mem_ack_i  = 1'b1;
        mem_data_i = 32'hDEAD_BEEF;
        #1;
        check("s3_late_valid", 32'(valid_o), 32'd0);
        check("s3_late_instr", 32'(instr_o == 32'hDEAD_BEEF), 32'd0);
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("s3_new_req", 32'(mem_req_o), 32'd1);
        check("s3_new_addr", mem_addr_o, 32'h40);
        check("s3_count0", 32'(count_o), 32'd0);
        mem_ack_i  = 1'b1;
        mem_data_i = mem_word(32'h40);
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("s3_head_valid", 32'(valid_o), 32'd1);
        check("s3_head_pc", pc_o, 32'h40);
        check("s3_head_instr", instr_o, mem_word(32'h40));
        check("s3_count1", 32'(count_o), 32'd1);

        // Redirect, ack and deq together; new PC also exercises 32-bit wrap.
        do_reset("s4");
        tick();
        mem_ack_i  = 1'b1;
        mem_data_i = mem_word(32'h0);
        tick();
        mem_ack_i     = 1'b1;
        mem_data_i    = 32'hBAD0_0004;
        deq_i         = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        #1;
        check("s4_pre_count", 32'(count_o), 32'd1);
        tick();
        mem_ack_i  = 1'b0;
        deq_i      = 1'b0;
        redirect_i = 1'b0;
        #1;
        check("s4_count", 32'(count_o), 32'd0);
        check("s4_valid", 32'(valid_o), 32'd0);
        check("s4_req", 32'(mem_req_o), 32'd1);
        check("s4_addr", mem_addr_o, 32'hFFFF_FFFC);
        tick();
        check("s4_addr_hold", mem_addr_o, 32'hFFFF_FFFC);
        mem_ack_i  = 1'b1;
        mem_data_i = mem_word(32'hFFFF_FFFC);
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("s4_head_valid", 32'(valid_o), 32'd1);
        check("s4_head_pc", pc_o, 32'hFFFF_FFFC);
        check("s4_head_pc4", pc_plus4_o, 32'h0);
        check("s4_head_instr", instr_o, mem_word(32'hFFFF_FFFC));
        check("s4_wrap_addr", mem_addr_o, 32'h0);

        // Ack into an empty queue with deq held high.
        do_reset("s6");
        deq_i = 1'b1;
        tick();
        mem_ack_i  = 1'b1;
        mem_data_i = 32'h2002_0005;
        #1;
`ifdef PREFETCH_BYPASS_EN
        check("s6_byp_valid", 32'(valid_o), 32'd1);
        check("s6_byp_instr", instr_o, 32'h2002_0005);
        check("s6_byp_pc", pc_o, 32'h0);
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("s6_byp_count", 32'(count_o), 32'd0);
        check("s6_byp_after", 32'(valid_o), 32'd0);
`else
        check("s6_reg_valid0", 32'(valid_o), 32'd0);
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("s6_reg_valid1", 32'(valid_o), 32'd1);
        check("s6_reg_instr", instr_o, 32'h2002_0005);
        check("s6_reg_count1", 32'(count_o), 32'd1);
        tick();
        check("s6_reg_count0", 32'(count_o), 32'd0);
`endif
        deq_i = 1'b0;

        // Slow memory with a consumer always ready: one-cycle pulses, in-order PCs.
        do_reset("s5");
        auto_mem   = 1'b1;
        ack_lat    = 5;
        deq_i      = 1'b1;
        pops       = 0;
        exp_pc     = 32'h0;
        prev_valid = 1'b0;
        for (int i = 0; i < 200 && pops < 8; i++) begin
            tick();
            check("s5_count_le1", 32'(count_o > CNT_W'(1)), 32'd0);
            check("s5_single_pulse", 32'(prev_valid && valid_o), 32'd0);
            if (valid_o && deq_i) begin
                check("s5_pop_pc", pc_o, exp_pc);
                check("s5_pop_instr", instr_o, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            prev_valid = valid_o;
        end
        check("s5_pops", 32'(pops), 32'd8);
        deq_i    = 1'b0;
        auto_mem = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Instruction prefetch buffer between a multi-cycle instruction memory and the pipelined CPU's IF stage.
- Fetches sequential words ahead of the pipeline and queues them with their PCs.
- Hands them to the IF/ID pipeline register on demand.
- Flushes and restarts fetch when the MEM stage resolves a taken branch (PCSrc redirect).

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- redirect_i  input  1  taken branch; flush queue and restart fetch.
- redirect_pc_i  input  32  new fetch address, sampled when redirect_i=1.
- mem_req_o  output  1  fetch request to instruction memory.
- mem_addr_o  output  32  fetch address; stable while mem_req_o=1.
- mem_ack_i  input  1  memory completes the request this cycle; mem_data_i is valid.
- mem_data_i  input  32  fetched instruction word.
- deq_i  input  1  consumer pops the head entry (IF/ID write enable).
- valid_o  output  1  head entry is available.
- instr_o  output  32  head instruction.
- pc_o  output  32  head entry PC.
- pc_plus4_o  output  32  pc_o + 4, combinational.
- count_o  output  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (rst_i=1 at an edge):
  - queue empty: count_o=0, valid_o=0; instr_o, pc_o = 0.
  - fetch_pc=RESET_PC; FSM=IDLE; mem_req_o=0.
  - Reset mid-request abandons the request; memory must tolerate req dropping.
- FSM states: IDLE, REQ, DROP.
- IDLE:
  - If count + 0 < DEPTH (space reserved), go to REQ next cycle.
  - mem_req_o=1 and mem_addr_o=fetch_pc from the cycle REQ is entered.
- REQ:
  - mem_req_o=1 and mem_addr_o held until mem_ack_i.
  - On ack without redirect: push {fetch_pc, mem_data_i}; fetch_pc += 4.
  - After ack, next state is REQ again if a free slot remains after this push and pop, else IDLE.
  - Back-to-back fetches are possible, one outstanding request maximum.
- DROP:
  - Entered when redirect_i=1 while in REQ without ack that cycle.
  - mem_req_o stays 1 with the old address until ack.
  - The returned data is discarded.
  - Then go to REQ at the redirected fetch_pc if space remains, else IDLE.
- Redirect (highest priority):
  - Queue cleared next cycle: count_o=0, valid_o=0.
  - fetch_pc=redirect_pc_i.
  - deq_i and any ack data in the same cycle are ignored and not pushed.
  - Redirect with ack in the same cycle: the request is complete, so go to REQ at the new PC, not DROP.
  - Redirect in DROP: update fetch_pc; stay in DROP.
- Queue:
  - Circular buffer with read/write pointers of width log2(DEPTH); wrap naturally.
  - Push and pop in the same cycle: count unchanged.
  - Pop on empty (deq_i=1, valid_o=0) is ignored.
  - Push never occurs when full; this is guaranteed by the issue check, which counts the outstanding request.
  - A push when full is an assertion failure in simulation.
- Latency: ack to valid_o is 1 cycle; pop to next head is 1 cycle.
- PC arithmetic: 32-bit, wraps modulo 2^32.

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- Defined:
  - When the queue is empty and an accepted ack (no redirect, not DROP) arrives, valid_o=1 in the same cycle.
  - instr_o=mem_data_i and pc_o=fetch_pc in that cycle.
  - If deq_i=1 that cycle, the word is consumed and not written to the queue; otherwise it is written as normal.
- Undefined: ack-to-valid_o latency is always 1 cycle; valid_o, instr_o and pc_o are purely registered.

Test Plan:
- Reset, then mem_ack_i one cycle after every request, deq_i=0 -> addresses 0x0, 0x4, 0x8, 0xC issued; count_o reaches 4; mem_req_o then 0; pc_o=0x0, pc_plus4_o=0x4.
- From full, deq_i=1 for one cycle -> count_o=3; a new request at 0x10 is issued; head pc_o=0x4.
- redirect_i=1 with redirect_pc_i=0x40 while a request at 0x8 is pending, ack two cycles later with 0xDEADBEEF -> FSM in DROP; 0xDEADBEEF never appears on instr_o; next mem_addr_o=0x40; first valid entry has pc_o=0x40.
- redirect_i, mem_ack_i and deq_i all 1 in one cycle -> queue empty next cycle, acked word discarded, next request at the redirect PC, no DROP.
- Memory stalls 5 cycles per ack while deq_i=1 continuously -> valid_o toggles 1 for a single cycle per word; no duplicate or skipped PCs; count_o never exceeds 1.
- PREFETCH_BYPASS_EN, empty queue, ack with 0x2002_0005 and deq_i=1 in the same cycle -> valid_o=1 and instr_o=0x2002_0005 that cycle; count_o stays 0.
